gray_rx_decoder: RTL and testbench

Downstream consumer of the binary-to-Gray converter. It synchronizes a Gray-coded count arriving from another producer, decodes it back to binary, and classifies each observed change as a legal ±1 step or an illegal jump. It sits on the receive side of a Gray-coded pointer or counter link and feeds binary position, step direction and error status to local logic.

---
 rtl/gray_rx_decoder.sv | 135 +++++++++++++
 tb/tb_gray_rx_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: synchronizes an asynchronous Gray-coded count, decodes it to
// binary and classifies every observed change as a +1/-1 step or an illegal jump.
module gray_rx_decoder #(
  parameter int unsigned VEC_W       = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [VEC_W-1:0]     gray_i,
  input  logic                 err_clr_i,
  output logic [VEC_W-1:0]     bin_o,
  output logic                 chg_o,
  output logic                 dir_o,
  output logic                 jump_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned CW = $clog2(SYNC_STAGES) + 1;

  typedef enum logic [1:0] {
    FILL,
    LOAD,
    RUN
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        fill_cnt, fill_nxt;
  logic [VEC_W-1:0]     sync_q [SYNC_STAGES];
  logic [VEC_W-1:0]     g_s;
  logic [VEC_W-1:0]     b_s;
  logic [VEC_W-1:0]     diff;
  logic [VEC_W-1:0]     prev;
  logic                 chg, dir, jump, err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 step_up, step_dn, is_jump;

  // Plain flop chain on the asynchronous input; nothing between stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it,
  // equivalent to the MSB-first ripple b[k] = b[k+1] ^ g[k].
  always_comb begin
    b_s = '0;
    for (int unsigned k = 0; k < VEC_W; k++) b_s[k] = ^(g_s >> k);
  end

  // Step classification against the last accepted value (mod 2^VEC_W).
  always_comb begin
    diff    = b_s - prev;
    step_up = (state == RUN) && (diff == VEC_W'(1));
    step_dn = (state == RUN) && (diff == '1);
    is_jump = (state == RUN) && (diff != '0) && !step_up && !step_dn;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
    end
  end

  // FSM next state: FILL waits for the synchronizer to flush, LOAD is one cycle.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    case (state)
      FILL: begin
        if (fill_cnt == CW'(SYNC_STAGES - 1)) begin
          state_nxt = LOAD;
          fill_nxt  = '0;
        end else begin
          fill_nxt = fill_cnt + CW'(1);
        end
      end
      LOAD:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = FILL;
    endcase
  end

  // Registered outputs: position, change pulses, sticky error and jump counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev    <= '0;
      chg     <= 1'b0;
      dir     <= 1'b0;
      jump    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      chg  <= 1'b0;
      jump <= 1'b0;
      if (state == LOAD) begin
        prev <= b_s;
      end else if (step_up || step_dn || is_jump) begin
        prev <= b_s;
        chg  <= 1'b1;
        dir  <= step_up;
        jump <= is_jump;
      end
      // A jump in the same cycle as a clear is counted after the clear.
      if (is_jump) begin
        err <= 1'b1;
        if (err_clr_i)          err_cnt <= ERR_CNT_W'(1);
        else if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end else if (err_clr_i) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

  assign bin_o     = prev;
  assign chg_o     = chg;
  assign dir_o     = dir;
  assign jump_o    = jump;
  assign err_o     = err;
  assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Scoreboard bench for gray_rx_decoder (VEC_W=5, SYNC_STAGES=2, ERR_CNT_W=8).
module tb_gray_rx_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] gray_i;
  logic       err_clr_i;
  logic [4:0] bin_o;
  logic       chg_o, dir_o, jump_o, err_o;
  logic [7:0] err_cnt_o;

  typedef struct {
    logic [4:0] bin;
    logic       dir;
    logic       jump;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  gray_rx_decoder #(.VEC_W(5), .SYNC_STAGES(2), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_i    (gray_i),
    .err_clr_i (err_clr_i),
    .bin_o     (bin_o),
    .chg_o     (chg_o),
    .dir_o     (dir_o),
    .jump_o    (jump_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] bin2gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_chg(input logic [4:0] b, input logic d, input logic j,
                            input logic e, input logic [7:0] c);
    exp_t x;
    x.bin = b; x.dir = d; x.jump = j; x.err = e; x.cnt = c;
    q.push_back(x);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bin"},  32'(bin_o), 0);
    check({tag, "_chg"},  32'(chg_o), 0);
    check({tag, "_dir"},  32'(dir_o), 0);
    check({tag, "_jump"}, 32'(jump_o), 0);
    check({tag, "_err"},  32'(err_o), 0);
    check({tag, "_cnt"},  32'(err_cnt_o), 0);
  endtask

  // Monitor: every chg_o pulse must match the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (chg_o) begin
        if (q.size() == 0) begin
          check("unexpected_chg", 32'(chg_o), 0);
        end else begin
          x = q.pop_front();
          check("mon_bin",  32'(bin_o), 32'(x.bin));
          check("mon_dir",  32'(dir_o), 32'(x.dir));
          check("mon_jump", 32'(jump_o), 32'(x.jump));
          check("mon_err",  32'(err_o), 32'(x.err));
          check("mon_cnt",  32'(err_cnt_o), 32'(x.cnt));
        end
      end else begin
        check("jump_without_chg", 32'(jump_o), 0);
      end
    end
  end

  initial begin
    logic [4:0] prev_b, nb;
    int         cnt;

    // 1. Reset load: 10110 decodes to 27.
    rst_n = 1'b0; gray_i = 5'b10110; err_clr_i = 1'b0;
    tick(); tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(); check("fill1_bin", 32'(bin_o), 0);
    tick(); check("fill2_bin", 32'(bin_o), 0);
    tick(); check("load_bin", 32'(bin_o), 27);
    tick(); check("load_err", 32'(err_o), 0);

    // Restart from zero for the sweep.
    rst_n = 1'b0; gray_i = 5'b00000;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("zero_bin", 32'(bin_o), 0);

    // 2. Up sweep including 31 -> 0 wrap, latency checked each step.
    prev_b = 5'd0;
    for (int i = 1; i <= 32; i++) begin
      nb = 5'(i);
      gray_i = bin2gray(nb);
      expect_chg(nb, 1'b1, 1'b0, 1'b0, 8'd0);
      tick(); tick();
      check("sweep_hold", 32'(bin_o), 32'(prev_b));
      tick();
      check("sweep_lat", 32'(bin_o), 32'(nb));
      tick();
      prev_b = nb;
    end
    check("sweep_cnt", 32'(err_cnt_o), 0);

    // 3. Down wrap 0 -> 31, then back up 31 -> 0.
    gray_i = 5'b10000;
    expect_chg(5'd31, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(); tick(); tick(); tick();
    gray_i = 5'b00000;
    expect_chg(5'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(); tick(); tick(); tick();

    // 4. Jump 0 -> 2, then legal 2 -> 3.
    gray_i = 5'b00011;
    expect_chg(5'd2, 1'b0, 1'b1, 1'b1, 8'd1);
    tick(); tick(); tick(); tick();
    gray_i = 5'b00010;
    expect_chg(5'd3, 1'b1, 1'b0, 1'b1, 8'd1);
    tick(); tick(); tick(); tick();
    check("err_sticky", 32'(err_o), 1);

    // 5a. Clear on the same edge as jump 3 -> 10: count restarts at 1.
    gray_i = 5'b01111;
    expect_chg(5'd10, 1'b0, 1'b1, 1'b1, 8'd1);
    tick(); tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("clr_jump_err", 32'(err_o), 1);
    check("clr_jump_cnt", 32'(err_cnt_o), 1);
    tick();

    // 5b. Plain clear.
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("clr_err", 32'(err_o), 0);
    check("clr_cnt", 32'(err_cnt_o), 0);
    check("clr_bin", 32'(bin_o), 10);

    // 5c. 300 back-to-back jumps alternating 0 and 2: counter saturates.
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      nb = (k % 2 == 0) ? 5'd0 : 5'd2;
      gray_i = bin2gray(nb);
      if (cnt < 255) cnt++;
      expect_chg(nb, 1'b0, 1'b1, 1'b1, 8'(cnt));
      tick();
    end
    tick(); tick(); tick(); tick();
    check("sat_cnt", 32'(err_cnt_o), 255);
    check("sat_err", 32'(err_o), 1);
    check("sat_bin", 32'(bin_o), 2);

    // 6. Mid-run reset with a change in flight; it must be discarded.
    gray_i = bin2gray(5'd3);
    tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1;
    tick(); tick();
    check("midrst_fill_bin", 32'(bin_o), 0);
    tick();
    check("midrst_load_bin", 32'(bin_o), 3);
    tick();

    // Normal operation resumes after the reload.
    gray_i = bin2gray(5'd4);
    expect_chg(5'd4, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(); tick(); tick(); tick(); tick();

    check("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
